mc_cmd_wr_arb: RTL

Round-robin burst arbiter that shares the single write port of the memory-controller command FIFO (`async_fifo`, write-clock side) among `NUM_REQ` requesters. A grant is held for a whole burst of 1..`BURST_MAX` beats, so bursts from different sources never interleave in the FIFO. The block runs entirely in the FIFO write-clock domain. It drives `wr_en`/`wr_data` directly and obeys the FIFO's registered `full` and `afull` flags.

---
 rtl/mc_arb_pkg.sv | 24 ++
 rtl/mc_cmd_wr_arb_if.sv | 36 +++
 rtl/mc_rr_pick.sv | 44 ++++
 rtl/mc_cmd_wr_arb.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/mc_arb_pkg.sv
// mc_arb_pkg: shared state type, width helpers and defaults for the
// memory-controller command arbiters (write-side burst arbiter and the
// read-return arbiter both pull from here).
package mc_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  // Default watchdog limit, in stalled XFER cycles.
  localparam int TIMEOUT_DEFAULT = 64;

  // Width of a burst-length field able to hold 0..burst_max.
  function automatic int len_width(input int burst_max);
    return $clog2(burst_max + 1);
  endfunction

  // Width of an encoded requester index (never narrower than 1 bit).
  function automatic int id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/mc_cmd_wr_arb_if.sv
// mc_cmd_wr_arb_if: requester-side and FIFO-write-side signals of the
// command write arbiter. master = requesters + FIFO (drive vld/len/data and
// full/afull), slave = the arbiter (drives rdy, FIFO write, status).
interface mc_cmd_wr_arb_if
  import mc_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_MAX  = 8
);
  localparam int LEN_WIDTH = len_width(BURST_MAX);
  localparam int ID_WIDTH  = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]            req_vld;
  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_rdy;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;
  logic                          fifo_full;
  logic                          fifo_afull;
  logic [ID_WIDTH-1:0]           gnt_id;
  logic                          busy;
  logic                          arb_err;

  modport master (
    output req_vld, req_len, req_data, fifo_full, fifo_afull,
    input  req_rdy, fifo_wr_en, fifo_wr_data, gnt_id, busy, arb_err
  );

  modport slave (
    input  req_vld, req_len, req_data, fifo_full, fifo_afull,
    output req_rdy, fifo_wr_en, fifo_wr_data, gnt_id, busy, arb_err
  );

endinterface

// File: rtl/mc_rr_pick.sv
// mc_rr_pick: combinational round-robin picker; first set request searching
//   circularly from i_ptr+1. Zero latency, no state, no backpressure.
// Ports: i_req (request vector), i_ptr (last winner), o_gnt_oh (one-hot
//   winner), o_gnt_idx (encoded winner), o_any (any request set).
module mc_rr_pick
  import mc_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  i_req,
  input  logic [ID_WIDTH-1:0] i_ptr,
  output logic [NUM_REQ-1:0]  o_gnt_oh,
  output logic [ID_WIDTH-1:0] o_gnt_idx,
  output logic                o_any
);

  logic w_found;

  // Two linear passes replace a modulo search: indices above the pointer
  // come first, then the wrap-around range 0..ptr.
  always_comb begin
    o_gnt_oh  = '0;
    o_gnt_idx = '0;
    w_found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && i_req[i] && (ID_WIDTH'(i) > i_ptr)) begin
        w_found     = 1'b1;
        o_gnt_oh[i] = 1'b1;
        o_gnt_idx   = ID_WIDTH'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && i_req[i] && (ID_WIDTH'(i) <= i_ptr)) begin
        w_found     = 1'b1;
        o_gnt_oh[i] = 1'b1;
        o_gnt_idx   = ID_WIDTH'(i);
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/mc_cmd_wr_arb.sv
// mc_cmd_wr_arb: round-robin burst arbiter onto the command FIFO write port.
// Latency: grant one edge after req_vld seen in IDLE; 1 beat/cycle, 1 bubble per burst.
// Backpressure: fifo_full stalls beats (req_rdy low), fifo_afull blocks new grants only.
// Ports: wr_clk, wr_rst_n (async active-low); bus (slave modport) carries
//   req_vld/len/data/rdy, fifo_wr_en/wr_data/full/afull, gnt_id, busy, arb_err.
// Optional: define MC_ARB_TIMEOUT_EN to build the stalled-grantee watchdog.
module mc_cmd_wr_arb
  import mc_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_MAX  = 8,
  parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic             wr_clk,
  input  logic             wr_rst_n,
  mc_cmd_wr_arb_if.slave   bus
);

  localparam int LEN_WIDTH = len_width(BURST_MAX);
  localparam int ID_WIDTH  = id_width(NUM_REQ);

  arb_state_e            r_state, w_state_nxt;
  logic [ID_WIDTH-1:0]   r_gnt_id;
  logic [ID_WIDTH-1:0]   r_rr_ptr;
  logic [LEN_WIDTH-1:0]  r_beat_cnt;

  logic [NUM_REQ-1:0]    w_win_oh;
  logic [ID_WIDTH-1:0]   w_win_idx;
  logic                  w_any;
  logic [LEN_WIDTH-1:0]  w_len_raw, w_len_clamp;
  logic [NUM_REQ-1:0]    w_gnt_oh;
  logic                  w_gnt_vld;
  logic [DATA_WIDTH-1:0] w_gnt_data;
  logic                  w_grant, w_beat, w_timeout;
  logic [NUM_REQ-1:0]    w_rdy;
  logic [DATA_WIDTH-1:0] w_wr_data;

  mc_rr_pick #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) u_pick (
    .i_req     (bus.req_vld),
    .i_ptr     (r_rr_ptr),
    .o_gnt_oh  (w_win_oh),
    .o_gnt_idx (w_win_idx),
    .o_any     (w_any)
  );

  // Length of the would-be winner, forced into 1..BURST_MAX.
  always_comb begin
    w_len_raw = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win_oh[i]) w_len_raw = bus.req_len[i*LEN_WIDTH +: LEN_WIDTH];
    end
    w_len_clamp = w_len_raw;
    if (w_len_raw == '0)
      w_len_clamp = LEN_WIDTH'(1);
    else if (w_len_raw > LEN_WIDTH'(BURST_MAX))
      w_len_clamp = LEN_WIDTH'(BURST_MAX);
  end

  // Current grantee's valid and data.
  always_comb begin
    w_gnt_oh   = '0;
    w_gnt_vld  = 1'b0;
    w_gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_WIDTH'(i) == r_gnt_id) begin
        w_gnt_oh[i] = 1'b1;
        w_gnt_vld   = bus.req_vld[i];
        w_gnt_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_beat      = 1'b0;
    w_rdy       = '0;
    w_wr_data   = '0;
    case (r_state)
      IDLE: begin
        if (w_any && !bus.fifo_afull) begin
          w_grant     = 1'b1;
          w_state_nxt = XFER;
        end
      end
      XFER: begin
        w_rdy  = w_gnt_oh & {NUM_REQ{~bus.fifo_full}};
        w_beat = w_gnt_vld & ~bus.fifo_full;
        if (w_beat) w_wr_data = w_gnt_data;
        if ((w_beat && (r_beat_cnt == LEN_WIDTH'(1))) || w_timeout)
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      r_state    <= IDLE;
      r_gnt_id   <= '0;
      r_rr_ptr   <= ID_WIDTH'(NUM_REQ - 1);
      r_beat_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_gnt_id   <= w_win_idx;
        r_rr_ptr   <= w_win_idx;
        r_beat_cnt <= w_len_clamp;
      end else if (w_timeout) begin
        r_beat_cnt <= '0;
      end else if (w_beat) begin
        r_beat_cnt <= r_beat_cnt - 1'b1;
      end
    end
  end

`ifdef MC_ARB_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  logic [IDLE_W-1:0] r_idle_cnt;
  logic              r_arb_err;
  logic              w_stall;

  // Only a grantee with nothing to send counts; a full FIFO is not its fault.
  assign w_stall   = (r_state == XFER) && !w_gnt_vld && !bus.fifo_full;
  assign w_timeout = w_stall && (r_idle_cnt == IDLE_W'(TIMEOUT - 1));

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      r_idle_cnt <= '0;
      r_arb_err  <= 1'b0;
    end else begin
      if (w_timeout || w_beat || w_grant) r_idle_cnt <= '0;
      else if (w_stall)                   r_idle_cnt <= r_idle_cnt + 1'b1;
      if (w_timeout) r_arb_err <= 1'b1;
    end
  end

  assign bus.arb_err = r_arb_err;
`else
  assign w_timeout   = 1'b0;
  assign bus.arb_err = 1'b0;
`endif

  assign bus.req_rdy      = w_rdy;
  assign bus.fifo_wr_en   = w_beat;
  assign bus.fifo_wr_data = w_wr_data;
  assign bus.gnt_id       = r_gnt_id;
  assign bus.busy         = (r_state == XFER);

endmodule
